// File: rtl/bus_server_responder_if.sv
// Bus bundle between the arbiter/clients side (master) and the server responder (slave).
// The responder takes address and client traffic in, and drives grant, data stream and ack out.
interface bus_server_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable;
    logic [1:0]            address_to_be_served;
    logic                  client_1_rq;
    logic                  client_2_rq;
    logic                  client_3_rq;
    logic                  client_4_rq;
    logic                  client_1_valid;
    logic                  client_2_valid;
    logic                  client_3_valid;
    logic                  client_4_valid;
    logic [DATA_WIDTH-1:0] client_1_data;
    logic [DATA_WIDTH-1:0] client_2_data;
    logic [DATA_WIDTH-1:0] client_3_data;
    logic [DATA_WIDTH-1:0] client_4_data;
    logic [3:0]            client_grant;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic [1:0]            data_out_addr;
    logic                  server_ack;
    logic                  timeout_flag;
    logic [15:0]           transfer_count;

    modport master (
        output enable, address_to_be_served,
        output client_1_rq, client_2_rq, client_3_rq, client_4_rq,
        output client_1_valid, client_2_valid, client_3_valid, client_4_valid,
        output client_1_data, client_2_data, client_3_data, client_4_data,
        input  client_grant, data_out, data_out_valid, data_out_addr,
        input  server_ack, timeout_flag, transfer_count
    );

    modport slave (
        input  enable, address_to_be_served,
        input  client_1_rq, client_2_rq, client_3_rq, client_4_rq,
        input  client_1_valid, client_2_valid, client_3_valid, client_4_valid,
        input  client_1_data, client_2_data, client_3_data, client_4_data,
        output client_grant, data_out, data_out_valid, data_out_addr,
        output server_ack, timeout_flag, transfer_count
    );
endinterface

// File: rtl/bus_server_responder.sv
// Server side of the strict-priority bus arbiter: grants the addressed client, streams up to
// BURST_LEN beats from it, then pulses server_ack so the arbiter computes the next address.
module bus_server_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input logic                  clk,
    input logic                  reset,
    bus_server_responder_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SERVE  = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);
    localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

    state_e                state_q, state_d;
    logic [1:0]            settle_cnt_q, settle_cnt_d;
    logic [1:0]            cur_addr_q, cur_addr_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [7:0]            idle_cnt_q, idle_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_out_valid_q, data_out_valid_d;
    logic [1:0]            data_out_addr_q, data_out_addr_d;
    logic                  timeout_flag_q, timeout_flag_d;
    logic [15:0]           transfer_count_q, transfer_count_d;

    logic [3:0]            rq_vec;
    logic [3:0]            valid_vec;
    logic [DATA_WIDTH-1:0] data_vec [4];
    logic                  sel_rq;
    logic                  sel_valid;
    logic                  latch_rq;

    assign rq_vec      = {bus.client_4_rq, bus.client_3_rq, bus.client_2_rq, bus.client_1_rq};
    assign valid_vec   = {bus.client_4_valid, bus.client_3_valid, bus.client_2_valid, bus.client_1_valid};
    assign data_vec[0] = bus.client_1_data;
    assign data_vec[1] = bus.client_2_data;
    assign data_vec[2] = bus.client_3_data;
    assign data_vec[3] = bus.client_4_data;

    // Served client is the latched one; the SETTLE decision uses the address being latched.
    assign sel_rq    = rq_vec[cur_addr_q];
    assign sel_valid = valid_vec[cur_addr_q];
    assign latch_rq  = rq_vec[bus.address_to_be_served];

    // NOTE: reset here is synchronous, so it sits inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            settle_cnt_q     <= '0;
            cur_addr_q       <= '0;
            beat_cnt_q       <= '0;
            idle_cnt_q       <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            data_out_addr_q  <= '0;
            timeout_flag_q   <= 1'b0;
            transfer_count_q <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q          <= state_d;
            settle_cnt_q     <= settle_cnt_d;
            cur_addr_q       <= cur_addr_d;
            beat_cnt_q       <= beat_cnt_d;
            idle_cnt_q       <= idle_cnt_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            data_out_addr_q  <= data_out_addr_d;
            timeout_flag_q   <= timeout_flag_d;
            transfer_count_q <= transfer_count_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d          = state_q;
        settle_cnt_d     = settle_cnt_q;
        cur_addr_d       = cur_addr_q;
        beat_cnt_d       = beat_cnt_q;
        idle_cnt_d       = idle_cnt_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        data_out_addr_d  = data_out_addr_q;
        timeout_flag_d   = 1'b0;
        transfer_count_d = transfer_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 2'd2;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 2'd1) begin
                    cur_addr_d = bus.address_to_be_served;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = latch_rq ? ST_SERVE : ST_ACK;
                end else begin
                    settle_cnt_d = settle_cnt_q - 2'd1;
                end
            end
            ST_SERVE: begin
                if (sel_valid) begin
                    data_out_d       = data_vec[cur_addr_q];
                    data_out_addr_d  = cur_addr_q;
                    data_out_valid_d = 1'b1;
                    beat_cnt_d       = beat_cnt_q + 8'd1;
                    idle_cnt_d       = '0;
                    transfer_count_d = transfer_count_q + 16'd1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
                if ((sel_valid && beat_cnt_d == BURST_LEN_C) || !sel_rq) begin
                    state_d = ST_ACK;
                end
                if (!sel_valid && idle_cnt_d == TIMEOUT_C) begin
                    state_d        = ST_ACK;
                    timeout_flag_d = 1'b1;
                end
            end
            ST_ACK: begin
                if (bus.enable) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 2'd2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.client_grant   = '0;
        bus.server_ack     = 1'b0;
        if (state_q == ST_SERVE) begin
            bus.client_grant = 4'b0001 << cur_addr_q;
        end
        if (state_q == ST_ACK) begin
            bus.server_ack = 1'b1;
        end
        bus.data_out       = data_out_q;
        bus.data_out_valid = data_out_valid_q;
        bus.data_out_addr  = data_out_addr_q;
        bus.timeout_flag   = timeout_flag_q;
        bus.transfer_count = transfer_count_q;
    end
endmodule
